// File: rtl/gate_sequencer.sv
// Drives a 2-input gate through all four input vectors, waits SETTLE cycles per vector,
// and captures y into result. The optional checker is enabled with GATE_SEQUENCER_CHECK_EN.
module gate_sequencer #(
    parameter int unsigned SETTLE = 3,
    parameter logic [3:0]  EXP    = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic [3:0] result,
    output logic       pass,
    output logic [2:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] result_q, result_d;

    logic accept;
    logic sample_edge;

    assign accept      = (state_q == ST_IDLE) && start && !abort;
    assign sample_edge = (state_q == ST_SAMPLE) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= 4'd0;
            result_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_SETTLE;
                    idx_d    = 2'd0;
                    cnt_d    = 4'd0;
                    result_d = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d[idx_q] = y;
                    // idx stays at 3 after the last vector rather than wrapping
                    if (idx_q != 2'd3) begin
                        idx_d   = idx_q + 2'd1;
                        cnt_d   = 4'd0;
                        state_d = ST_SETTLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done   = (state_q == ST_DONE);
    assign a      = busy & idx_q[1];
    assign b      = busy & idx_q[0];
    assign result = result_q;

`ifdef GATE_SEQUENCER_CHECK_EN
    logic [2:0] err_q, err_d;
    logic       pass_q, pass_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q  <= 3'd0;
            pass_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            pass_q <= pass_d;
        end
    end

    always_comb begin
        err_d  = err_q;
        pass_d = pass_q;
        if (accept) begin
            err_d  = 3'd0;
            pass_d = 1'b0;
        end
        if (sample_edge) begin
            if (y != EXP[idx_q]) begin
                err_d = err_q + 3'd1;
            end
            // pass reflects the count including this final sample
            if (idx_q == 2'd3) begin
                pass_d = (err_d == 3'd0);
            end
        end
    end

    assign err_cnt = err_q;
    assign pass    = pass_q;
`else
    assign err_cnt = 3'd0;
    assign pass    = 1'b0;
`endif

endmodule
